uart_rx_controller: RTL and testbench

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_controller_if.sv | 30 +++
 rtl/uart_rx_controller_edge_bit_counter.sv | 43 ++++
 rtl/uart_rx_controller.sv | 154 +++++++++++++++
 tb/tb_uart_rx_controller.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive path.
// Holds the controller state encoding, legal prescale set and frame width.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int PS_8      = 8;
    localparam int PS_16     = 16;
    localparam int PS_32     = 32;
    localparam int DATA_BITS = 8;

    // Any oversampling ratio outside the legal set falls back to 8.
    function automatic int norm_prescale(input int p);
        return (p == PS_16 || p == PS_32) ? p : PS_8;
    endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// uart_rx_controller_if: line, configuration and sampler/deserializer strobes.
// master drives the line and configuration, slave is the controller.
interface uart_rx_controller_if #(
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  sampled_bit;
    logic                  dat_samp_en;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  deser_en;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        input  dat_samp_en, edge_cnt, deser_en,
        input  data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        output dat_samp_en, edge_cnt, deser_en,
        output data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_controller_edge_bit_counter.sv
// edge_bit_counter: oversampling edge counter plus data-bit index.
// edge_cnt wraps at 'last'; bit_idx advances on each wrap when bit_en is set.
module edge_bit_counter #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  bit_en,
    input  logic [PRESCALE_W-1:0] last,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]      bit_idx,
    output logic                  wrap
);
    import uart_rx_pkg::*;

    assign wrap = en && (edge_cnt == last);

    // Edge index within the current bit, wrapping at the end of each bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
        end else if (en) begin
            edge_cnt <= wrap ? '0 : edge_cnt + 1'b1;
        end
    end

    // Data-bit index, advanced once per completed data bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_idx <= '0;
        end else if (clr) begin
            bit_idx <= '0;
        end else if (bit_en && wrap) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: UART receive frame sequencer.
// Walks start/data/parity/stop bits and raises one-cycle frame-end pulses.
module uart_rx_controller #(
    parameter int PRESCALE_W = 6,
    parameter int DATA_BITS  = uart_rx_pkg::DATA_BITS
) (
    input logic                 CLK,
    input logic                 RST,
    uart_rx_controller_if.slave bus
);
    import uart_rx_pkg::*;

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    state_e                state;
    state_e                state_n;
    logic                  start_entry;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  cnt_bit_en;
    logic                  wrap;
    logic                  deser;
    logic                  stop_dec;
    logic                  busy_c;
    logic [BIT_W-1:0]      bit_idx;
    logic [PRESCALE_W-1:0] last_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_acc;
    logic                  par_fail;
    logic                  valid_q;
    logic                  perr_q;
    logic                  serr_q;

    edge_bit_counter #(
        .PRESCALE_W(PRESCALE_W),
        .BIT_W     (BIT_W)
    ) u_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .bit_en  (cnt_bit_en),
        .last    (last_q),
        .edge_cnt(bus.edge_cnt),
        .bit_idx (bit_idx),
        .wrap    (wrap)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle controls; decisions only on the last edge.
    always_comb begin
        state_n     = state;
        start_entry = 1'b0;
        busy_c      = (state != IDLE);
        deser       = (state == DATA) && wrap;
        stop_dec    = (state == STOP) && wrap;
        unique case (state)
            IDLE: begin
                if (!bus.RX_IN) begin
                    state_n     = START;
                    start_entry = 1'b1;
                end
            end
            START: begin
                if (wrap) begin
                    state_n = bus.sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (wrap && bit_idx == LAST_BIT) begin
                    state_n = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (wrap) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    if (!bus.RX_IN) begin
                        state_n     = START;
                        start_entry = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        cnt_en     = busy_c;
        cnt_clr    = (state == IDLE) || start_entry;
        cnt_bit_en = (state == DATA);
    end

    // Frame configuration, sampled fresh at the start of every frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (start_entry) begin
            last_q    <= PRESCALE_W'(norm_prescale(int'(bus.Prescale)) - 1);
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
        end
    end

    // Running data parity and the latched parity-fail flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_acc  <= 1'b0;
            par_fail <= 1'b0;
        end else if (start_entry) begin
            par_acc  <= 1'b0;
            par_fail <= 1'b0;
        end else if (deser) begin
            par_acc <= par_acc ^ bus.sampled_bit;
        end else if (state == PARITY && wrap) begin
            par_fail <= (par_acc ^ par_typ_q) != bus.sampled_bit;
        end
    end

    // Frame-end pulses, registered off the stop-bit decision.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            valid_q <= stop_dec && bus.sampled_bit && !par_fail;
            perr_q  <= stop_dec && par_fail;
            serr_q  <= stop_dec && !bus.sampled_bit;
        end
    end

    assign bus.dat_samp_en = busy_c;
    assign bus.busy        = busy_c;
    assign bus.deser_en    = deser;
    assign bus.data_valid  = valid_q;
    assign bus.par_err     = perr_q;
    assign bus.stp_err     = serr_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: table, directed and random frames for the controller.
// Expected pulses, bytes and timing come from frame rules, not the DUT.
module tb_uart_rx_controller;

    localparam int PW = 6;

    typedef struct {
        int         cfg_ps;
        int         bl;
        bit         pe;
        bit         pt;
        logic [7:0] d;
        bit         flip;
        bit         stp;
        bit         x_valid;
        bit         x_perr;
        bit         x_serr;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;

    uart_rx_controller_if #(.PRESCALE_W(PW)) ifc ();

    uart_rx_controller #(
        .PRESCALE_W(PW),
        .DATA_BITS (8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(ifc.slave)
    );

    always #5 CLK = ~CLK;

    // Ideal data sampler: reports the line value from the previous edge.
    always @(posedge CLK) ifc.sampled_bit <= RST ? 1'b1 : ifc.RX_IN;

    int         cyc       = 0;
    int         n_strobe  = 0;
    int         n_valid   = 0;
    int         n_perr    = 0;
    int         n_serr    = 0;
    int         n_glitch  = 0;
    int         pulse_cyc = 0;
    logic [7:0] shreg     = 8'h00;
    logic [7:0] vbyte [256];
    int         vcyc  [256];
    int         n_checks  = 0;
    int         n_fail    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Downstream deserializer and pulse recorder.
    always @(negedge CLK) begin
        if (ifc.deser_en) begin
            n_strobe <= n_strobe + 1;
            shreg    <= {ifc.sampled_bit, shreg[7:1]};
        end
        if (ifc.data_valid) begin
            vbyte[n_valid % 256] <= shreg;
            vcyc[n_valid % 256]  <= cyc;
            n_valid <= n_valid + 1;
        end
        if (ifc.par_err) n_perr <= n_perr + 1;
        if (ifc.stp_err) n_serr <= n_serr + 1;
        if (ifc.data_valid || ifc.par_err || ifc.stp_err) pulse_cyc <= cyc;
        if (ifc.deser_en && !ifc.busy) n_glitch <= n_glitch + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #3;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic scramble_cfg();
        ifc.Prescale = PW'($urandom);
        ifc.PAR_EN   = 1'($urandom);
        ifc.PAR_TYP  = 1'($urandom);
    endtask

    // Drive one frame, each bit held bl cycles; lim>=0 stops after lim bits.
    task automatic send_frame(input int cfg_ps, input int bl, input bit pe,
                              input bit pt, input logic [7:0] d, input bit flip,
                              input bit stp, input int lim, output int s);
        logic [11:0] bits;
        int          nb;
        bits    = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        nb = 9;
        if (pe) begin
            bits[nb] = (^d) ^ pt ^ flip;
            nb = nb + 1;
        end
        bits[nb] = stp;
        nb = nb + 1;
        if (lim >= 0 && lim < nb) nb = lim;
        s = cyc;
        ifc.Prescale = PW'(cfg_ps);
        ifc.PAR_EN   = pe;
        ifc.PAR_TYP  = pt;
        for (int k = 0; k < nb; k++) begin
            ifc.RX_IN = bits[k];
            for (int j = 0; j < bl; j++) begin
                tick();
                if (k == 0 && j == 0) scramble_cfg();
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int s0, v0, p0, e0, s, idx, nf;
        s0 = n_strobe;
        v0 = n_valid;
        p0 = n_perr;
        e0 = n_serr;
        send_frame(v.cfg_ps, v.bl, v.pe, v.pt, v.d, v.flip, v.stp, -1, s);
        ifc.RX_IN = 1'b1;
        repeat (4) tick();
        nf = 10 + (v.pe ? 1 : 0);
        check({nm, ".strobes"}, n_strobe - s0, 8);
        check({nm, ".valid"}, n_valid - v0, int'(v.x_valid));
        check({nm, ".par_err"}, n_perr - p0, int'(v.x_perr));
        check({nm, ".stp_err"}, n_serr - e0, int'(v.x_serr));
        check({nm, ".latency"}, pulse_cyc - s, nf * v.bl + 1);
        if (v.x_valid) begin
            idx = (n_valid - 1) % 256;
            check({nm, ".byte"}, int'(vbyte[idx]), int'(v.d));
        end
        check({nm, ".idle"}, int'(ifc.busy), 0);
    endtask

    initial begin
        vec_t tbl [7];
        vec_t r;
        int   s, s0, v0, p0, e0, i1, i2, pick, cfg;

        tbl[0] = '{8,  8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{16, 16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16, 16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8,  8,  1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{12, 8,  1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{32, 32, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{0,  8,  1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        RST          = 1'b1;
        ifc.RX_IN    = 1'b1;
        ifc.Prescale = PW'(8);
        ifc.PAR_EN   = 1'b0;
        ifc.PAR_TYP  = 1'b0;
        repeat (3) tick();
        check("reset.outs", int'({ifc.busy, ifc.dat_samp_en, ifc.deser_en,
              ifc.data_valid, ifc.par_err, ifc.stp_err}), 0);
        check("reset.edge_cnt", int'(ifc.edge_cnt), 0);
        ifc.RX_IN = 1'b0;
        tick();
        check("reset.line_low", int'(ifc.busy), 0);
        ifc.RX_IN = 1'b1;
        tick();
        RST = 1'b0;
        repeat (3) tick();
        check("release.idle", int'(ifc.busy), 0);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Start glitch: two low cycles then high again.
        s0 = n_strobe;
        v0 = n_valid + n_perr + n_serr;
        ifc.Prescale = PW'(8);
        ifc.RX_IN    = 1'b0;
        tick();
        tick();
        check("glitch.busy", int'(ifc.busy), 1);
        ifc.RX_IN = 1'b1;
        repeat (12) tick();
        check("glitch.idle", int'(ifc.busy), 0);
        check("glitch.strobes", n_strobe - s0, 0);
        check("glitch.pulses", n_valid + n_perr + n_serr - v0, 0);

        // Stop error with the line left low: restarts a frame.
        s0 = n_strobe;
        v0 = n_valid;
        e0 = n_serr;
        send_frame(32, 32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, -1, s);
        tick();
        tick();
        check("stop.stp_err", n_serr - e0, 1);
        check("stop.valid", n_valid - v0, 0);
        check("stop.latency", pulse_cyc - s, 10 * 32 + 1);
        check("stop.restart", int'(ifc.busy), 1);
        ifc.RX_IN = 1'b1;
        repeat (40) tick();
        check("stop.idle", int'(ifc.busy), 0);
        check("stop.strobes", n_strobe - s0, 8);
        check("stop.one_err", n_serr - e0, 1);

        // Back-to-back frames with no idle gap.
        s0 = n_strobe;
        v0 = n_valid;
        send_frame(16, 16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1, s);
        send_frame(16, 16, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, -1, s);
        ifc.RX_IN = 1'b1;
        repeat (4) tick();
        check("b2b.valid", n_valid - v0, 2);
        check("b2b.strobes", n_strobe - s0, 16);
        i1 = (n_valid - 2) % 256;
        i2 = (n_valid - 1) % 256;
        check("b2b.byte0", int'(vbyte[i1]), 8'h55);
        check("b2b.byte1", int'(vbyte[i2]), 8'h0F);
        check("b2b.gap", vcyc[i2] - vcyc[i1], 10 * 16);

        // Reset after the fourth shift strobe, then a clean frame.
        s0 = n_strobe;
        v0 = n_valid;
        p0 = n_perr;
        e0 = n_serr;
        send_frame(8, 8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 5, s);
        tick();
        check("rstmid.strobes", n_strobe - s0, 4);
        RST       = 1'b1;
        ifc.RX_IN = 1'b1;
        #1;
        check("rstmid.outs", int'({ifc.busy, ifc.dat_samp_en, ifc.deser_en,
              ifc.data_valid, ifc.par_err, ifc.stp_err}), 0);
        check("rstmid.edge_cnt", int'(ifc.edge_cnt), 0);
        repeat (2) tick();
        RST = 1'b0;
        repeat (20) tick();
        check("rstmid.no_pulse", (n_valid - v0) + (n_perr - p0) + (n_serr - e0), 0);
        check("rstmid.idle", int'(ifc.busy), 0);
        r = '{8, 8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_vec(r, "rstmid.next");

        // Random frames checked against the frame rules.
        for (int i = 0; i < 24; i++) begin
            pick = $urandom_range(0, 3);
            if (pick == 3) begin
                cfg = $urandom_range(0, 63);
                if (cfg == 8 || cfg == 16 || cfg == 32) cfg = 5;
                r.cfg_ps = cfg;
                r.bl     = 8;
            end else begin
                r.cfg_ps = 8 << pick;
                r.bl     = 8 << pick;
            end
            r.pe      = 1'($urandom);
            r.pt      = 1'($urandom);
            r.d       = 8'($urandom);
            r.flip    = ($urandom_range(0, 3) == 0);
            r.stp     = ($urandom_range(0, 3) != 0);
            r.x_perr  = r.pe && r.flip;
            r.x_serr  = !r.stp;
            r.x_valid = r.stp && !r.x_perr;
            run_vec(r, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 5)) tick();
        end

        check("no_strobe_outside_frame", n_glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
